// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 2048x16 SRAM sequencer.
// Optional feature macro: SRAM_CTRL_RR_EN (round-robin arbitration).
package sram_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_CAP,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD
    } state_t;

    typedef logic req_idx_t;

    function automatic logic [1:0] idx_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_arb2.sv
// Two-requester arbiter: round-robin under SRAM_CTRL_RR_EN, fixed priority (requester 0) otherwise.
module sram_arb2
    import sram_ctrl_pkg::*;
(
`ifdef SRAM_CTRL_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant_c,
    output req_idx_t   idx_c
);

`ifdef SRAM_CTRL_RR_EN
    logic ptr;

    // Pointer names the requester that wins the next tie; it moves past each winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~idx_c;
        end
    end

    always_comb begin
        idx_c   = 1'b0;
        grant_c = 2'b00;
        if (req == 2'b11) begin
            idx_c = ptr;
        end else begin
            idx_c = req[1];
        end
        if (req != 2'b00) begin
            grant_c = idx_onehot(idx_c);
        end
    end
`else
    always_comb begin
        idx_c   = 1'b0;
        grant_c = 2'b00;
        idx_c   = (req == 2'b10);
        if (req != 2'b00) begin
            grant_c = idx_onehot(idx_c);
        end
    end
`endif

endmodule

// File: rtl/sram_ctrl.sv
// Two-port sequencer for an async-read, strobe-written SRAM; owns the shared data bus.
// Optional feature macro: SRAM_CTRL_RR_EN (round-robin arbitration between requesters).
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_adrx,
    output logic              sram_noe,
    output logic              sram_read,
    inout  wire  [DATA_W-1:0] sram_data
);

    localparam int unsigned CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    req_idx_t           idx;
    req_idx_t           win_c;
    logic [1:0]         grant_c;
    logic               accept_c;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               drive;
    logic               noe_d, read_d, drive_d;
    logic [1:0]         ack_d;

    assign accept_c  = (state == S_IDLE) && (grant_c != 2'b00);
    assign sram_adrx = addr_q;
    assign sram_data = drive ? wdata_q : 'z;

    sram_arb2 u_arb (
`ifdef SRAM_CTRL_RR_EN
        .clk     (clk),
        .rst     (rst),
        .accept  (accept_c),
`endif
        .req     (req),
        .grant_c (grant_c),
        .idx_c   (win_c)
    );

    // Output registers mirror the current state, so pins lag state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            drive     <= 1'b0;
            sram_noe  <= 1'b1;
            sram_read <= 1'b0;
            ack       <= 2'b00;
            rdata     <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            drive     <= drive_d;
            sram_noe  <= noe_d;
            sram_read <= read_d;
            ack       <= ack_d;
            if (accept_c) begin
                idx     <= win_c;
                addr_q  <= win_c ? addr1 : addr0;
                wdata_q <= win_c ? wdata1 : wdata0;
            end
            if (state == S_RD_CAP) begin
                rdata <= sram_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        noe_d      = 1'b1;
        read_d     = 1'b0;
        drive_d    = 1'b0;
        ack_d      = 2'b00;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    if (we[win_c]) begin
                        state_next = S_WR_SETUP;
                    end else begin
                        state_next = S_RD_WAIT;
                        cnt_next   = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            S_RD_WAIT: begin
                noe_d = 1'b0;
                if (cnt == '0) begin
                    state_next = S_RD_CAP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_RD_CAP: begin
                noe_d      = 1'b0;
                ack_d      = idx_onehot(idx);
                state_next = S_IDLE;
            end
            S_WR_SETUP: begin
                drive_d    = 1'b1;
                state_next = S_WR_STROBE;
            end
            S_WR_STROBE: begin
                drive_d    = 1'b1;
                read_d     = 1'b1;
                state_next = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                drive_d    = 1'b1;
                ack_d      = idx_onehot(idx);
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a behavioural 2048x16 SRAM on the shared bus.
module tb_sram_ctrl;

    localparam int WR_TICKS = 4;
    localparam int RD_TICKS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [10:0] addr0 = '0;
    logic [10:0] addr1 = '0;
    logic [15:0] wdata0 = '0;
    logic [15:0] wdata1 = '0;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic [10:0] sram_adrx;
    logic        sram_noe;
    logic        sram_read;
    wire  [15:0] sram_data;

    logic [15:0] mem [0:2047];
    int          wr_count = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sram_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .rdata     (rdata),
        .sram_adrx (sram_adrx),
        .sram_noe  (sram_noe),
        .sram_read (sram_read),
        .sram_data (sram_data)
    );

    // SRAM model: asynchronous read while nOE low, write on rising strobe.
    assign sram_data = sram_noe ? 16'hzzzz : mem[sram_adrx];

    always @(posedge sram_read) begin
        mem[sram_adrx] <= sram_data;
        wr_count       <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("ack_not_both", 32'(ack == 2'b11), 32'd0);
        check("bus_exclusive", 32'(!sram_noe && dut.drive), 32'd0);
    endtask

    task automatic wait_ack(output logic [1:0] a, output int c);
        a = 2'b00;
        c = 0;
        while (a == 2'b00 && c < 12) begin
            tick();
            c++;
            a = ack;
        end
    endtask

    task automatic xfer(input int r, input logic w, input logic [10:0] ad,
                        input logic [15:0] d, input string tag);
        logic [1:0] a;
        int         c;
        if (r == 0) begin
            addr0 = ad; wdata0 = d; we[0] = w; req[0] = 1'b1;
        end else begin
            addr1 = ad; wdata1 = d; we[1] = w; req[1] = 1'b1;
        end
        wait_ack(a, c);
        req = 2'b00;
        check({tag, "_latency"}, 32'(c), 32'(w ? WR_TICKS : RD_TICKS));
        check({tag, "_ack"}, 32'(a), (r == 0) ? 32'd1 : 32'd2);
    endtask

    initial begin
        logic [1:0] a;
        int         c;
        int         wr_before;

        tick();
        tick();
        check("rst_noe", 32'(sram_noe), 32'd1);
        check("rst_strobe", 32'(sram_read), 32'd0);
        check("rst_drive", 32'(dut.drive), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_adrx", 32'(sram_adrx), 32'd0);
        rst = 1'b0;
        tick();

        xfer(0, 1'b1, 11'h123, 16'hBEEF, "wr_beef");
        check("mem_123", 32'(mem[11'h123]), 32'hBEEF);
        xfer(0, 1'b0, 11'h123, 16'h0000, "rd_beef");
        check("rdata_beef", 32'(rdata), 32'hBEEF);

        xfer(1, 1'b1, 11'h000, 16'h0001, "wr_lo");
        xfer(1, 1'b1, 11'h7FF, 16'hFFFF, "wr_hi");
        check("rdata_hold_over_write", 32'(rdata), 32'hBEEF);
        xfer(0, 1'b0, 11'h000, 16'h0000, "rd_lo");
        check("rdata_lo", 32'(rdata), 32'h0001);
        xfer(0, 1'b0, 11'h7FF, 16'h0000, "rd_hi");
        check("rdata_hi", 32'(rdata), 32'hFFFF);

        // Reset while in WR_SETUP must abort before the strobe.
        xfer(0, 1'b1, 11'h055, 16'h5555, "wr_pre");
        wr_before = wr_count;
        addr0 = 11'h055; wdata0 = 16'hAAAA; we[0] = 1'b1; req[0] = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_noe", 32'(sram_noe), 32'd1);
        check("arst_strobe", 32'(sram_read), 32'd0);
        check("arst_drive", 32'(dut.drive), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_rdata", 32'(rdata), 32'd0);
        req = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("arst_no_ack", 32'(ack), 32'd0);
        check("arst_no_write", 32'(wr_count), 32'(wr_before));
        check("arst_mem_kept", 32'(mem[11'h055]), 32'h5555);
        xfer(1, 1'b0, 11'h055, 16'h0000, "rd_kept");
        check("rdata_kept", 32'(rdata), 32'h5555);

        // Both requesters hold continuous writes.
        addr0 = 11'h010; wdata0 = 16'h1111;
        addr1 = 11'h011; wdata1 = 16'h2222;
        we = 2'b11;
        req = 2'b11;
`ifdef SRAM_CTRL_RR_EN
        for (int i = 0; i < 4; i++) begin
            wait_ack(a, c);
            if (i == 3) req = 2'b00;
            check("rr_latency", 32'(c), 32'(WR_TICKS));
            check("rr_grant", 32'(a), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
`else
        for (int i = 0; i < 3; i++) begin
            wait_ack(a, c);
            if (i == 2) req[0] = 1'b0;
            check("fp_latency", 32'(c), 32'(WR_TICKS));
            check("fp_grant0", 32'(a), 32'd1);
        end
        wait_ack(a, c);
        req = 2'b00;
        check("fp_req1_latency", 32'(c), 32'(WR_TICKS));
        check("fp_req1_grant", 32'(a), 32'd2);
`endif
        check("mem_010", 32'(mem[11'h010]), 32'h1111);
        check("mem_011", 32'(mem[11'h011]), 32'h2222);
        tick();
        check("idle_ack", 32'(ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
